mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Instruction-fetch port (IF): read-only.
  - Load/store port (LS): read and write, driven by the mem-access stage.
- Arbitrates with LS priority plus a fetch anti-starvation limit.
- Sequences fixed-latency memory reads and routes read data back to the owning requester.
- At most one read outstanding.
- Sits between the fetch/mem-access stages and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4), counted from the mem_re_o cycle to the cycle mem_rdata_i is valid.
- MAX_LS_STREAK, 4, consecutive LS grants while IF waits before IF is forced through (legal 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch read request; held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DATA_W  fetch read data
- ls_req_i  in  1  load/store request; held until ls_gnt_o
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_gnt_o  out  1  load/store request accepted this cycle
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  DATA_W  load data
- mem_re_o  out  1  memory read strobe
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_re_o

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE, lat_cnt = 0, owner = IF, streak = 0.
  - Reset mid-read abandons the read: no rvalid is ever produced for it.
- States:
  - IDLE: may grant.
  - WAIT_RD: read outstanding; lat_cnt counts down from MEM_LAT.
- Grant selection in IDLE (combinational, same cycle):
  - if_req_i high and (ls_req_i low or streak == MAX_LS_STREAK) → IF wins.
  - Otherwise ls_req_i high → LS wins.
  - Neither → no grant.
  - Exactly one of if_gnt_o / ls_gnt_o is high in a grant cycle; neither is ever high outside IDLE.
- Memory drive on grant:
  - mem_addr_o = winner's address.
  - IF grant, or LS grant with ls_we_i = 0: mem_re_o = 1; next state WAIT_RD; lat_cnt = MEM_LAT; owner = winner.
  - LS grant with ls_we_i = 1: mem_we_o = 1 and mem_wdata_o = ls_wdata_i. No rvalid. State stays IDLE, so back-to-back stores are one per cycle.
  - When not granting, mem_addr_o and mem_wdata_o are 0.
- Streak counter:
  - +1 on an LS grant while if_req_i is high; saturates at MAX_LS_STREAK.
  - Cleared on any IF grant.
  - Unchanged on an LS grant while if_req_i is low.
- WAIT_RD:
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt reaches 0 (MEM_LAT cycles after the grant cycle), assert owner's rvalid for exactly one cycle, with owner's rdata = mem_rdata_i. State returns to IDLE on the next edge.
  - No grant is given in the rvalid cycle, so the earliest next grant is the cycle after rvalid. Read throughput = one per MEM_LAT + 1 cycles.
- rdata outputs are 0 whenever their rvalid is low.
- Requests arriving during WAIT_RD are held by the requester and arbitrated on return to IDLE.
- Request dropped before grant: no grant given, no state change. Requester protocol forbids this, but the arbiter tolerates it.

Test Plan:
- Reset mid-read:
  - MEM_LAT = 2: IF read to 0x100, assert rst the cycle after the grant.
  - Required: all outputs 0 immediately; no if_rvalid_o ever follows.
  - After release with no requests: state IDLE, outputs remain 0.
- Single fetch:
  - MEM_LAT = 1: if_req_i = 1, addr 0x40, mem returns 0xDEADBEEF.
  - Required: if_gnt_o and mem_re_o high in cycle 0 with mem_addr_o = 0x40; if_rvalid_o = 1 with 0xDEADBEEF in cycle 1; next grant possible in cycle 2.
- Simultaneous requests:
  - if_req_i and ls_req_i both high, LS load from 0x200.
  - Required: ls_gnt_o wins, streak = 1, ls_rvalid_o after MEM_LAT cycles; IF granted in the next IDLE cycle only if LS is idle.
- Starvation limit:
  - MAX_LS_STREAK = 4; LS issues continuous stores while IF requests.
  - Required: four ls_gnt_o pulses, then if_gnt_o on the 5th grant cycle; streak cleared to 0.
- Back-to-back stores:
  - Three stores: 0x10 ← 0x1, 0x14 ← 0x2, 0x18 ← 0x3.
  - Required: mem_we_o high three consecutive cycles with matching addr/data; no rvalid on either port.
- Latency sweep:
  - MEM_LAT = 4: LS load; IF request arrives during WAIT_RD.
  - Required: ls_rvalid_o exactly 4 cycles after grant; no grant during the wait; IF granted the cycle after ls_rvalid_o.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port data memory between the fetch port (read-only) and the
// load/store port, with LS priority, a fetch anti-starvation limit and fixed-latency reads.
module mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MEM_LAT       = 1,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   // Handshake: a requester holds req and its address/data until it sees gnt; the transfer
   // happens in the cycle where req and gnt are both high. rvalid is a one-cycle pulse.

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

   state_t     state_q, state_d;
   owner_t     owner_q, owner_d;
   logic [2:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] streak_q, streak_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_IF;
         lat_cnt_q <= '0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
         streak_q  <= streak_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_cnt_d   = lat_cnt_q;
      streak_d    = streak_q;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      ls_rdata_o  = '0;
      mem_re_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is held so every output reads 0 at once.
            if (!rst) begin
               if (if_req_i && (!ls_req_i || streak_q == STREAK_MAX)) begin
                  if_gnt_o   = 1'b1;
                  mem_re_o   = 1'b1;
                  mem_addr_o = if_addr_i;
                  state_d    = WAIT_RD;
                  lat_cnt_d  = LAT_INIT;
                  owner_d    = OWN_IF;
                  streak_d   = '0;
               end else if (ls_req_i) begin
                  ls_gnt_o   = 1'b1;
                  mem_addr_o = ls_addr_i;
                  if (if_req_i && streak_q != STREAK_MAX) begin
                     streak_d = streak_q + 4'd1;
                  end
                  if (ls_we_i) begin
                     mem_we_o    = 1'b1;
                     mem_wdata_o = ls_wdata_i;
                  end else begin
                     mem_re_o  = 1'b1;
                     state_d   = WAIT_RD;
                     lat_cnt_d = LAT_INIT;
                     owner_d   = OWN_LS;
                  end
               end
            end
         end

         WAIT_RD: begin
            lat_cnt_d = lat_cnt_q - 3'd1;
            // Count hits zero this cycle: the memory data is valid now, hand it to the owner.
            if (lat_cnt_q == 3'd1) begin
               state_d = IDLE;
               if (owner_q == OWN_LS) begin
                  ls_rvalid_o = 1'b1;
                  ls_rdata_o  = mem_rdata_i;
               end else begin
                  if_rvalid_o = 1'b1;
                  if_rdata_o  = mem_rdata_i;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
